// File: rtl/floo_sa_global_if.sv
// Request, grant and credit signals between the per-input allocators, the
// downstream credit return path and one output port's global switch allocator.
interface floo_sa_global_if #(
  parameter int NumInputs  = 5,
  parameter int NumVC      = 4,
  parameter int VCDepth    = 3,
  parameter int NumVCWidth = NumVC > 1 ? $clog2(NumVC) : 1,
  parameter int NumInWidth = NumInputs > 1 ? $clog2(NumInputs) : 1,
  parameter int CntWidth   = $clog2(VCDepth + 1)
);
  logic [NumInputs-1:0]                 req_v_i;
  logic [NumInputs-1:0][NumVCWidth-1:0] req_vc_id_i;
  logic [NumInputs-1:0]                 req_last_i;
  logic                                 grant_v_o;
  logic [NumInputs-1:0]                 grant_oh_o;
  logic [NumInWidth-1:0]                grant_id_o;
  logic [NumVCWidth-1:0]                grant_vc_id_o;
  logic                                 credit_v_i;
  logic [NumVCWidth-1:0]                credit_id_i;
  logic [NumVC-1:0][CntWidth-1:0]       credit_cnt_o;
  logic                                 locked_o;

  modport master (
    output req_v_i, req_vc_id_i, req_last_i, credit_v_i, credit_id_i,
    input  grant_v_o, grant_oh_o, grant_id_o, grant_vc_id_o, credit_cnt_o, locked_o
  );

  modport slave (
    input  req_v_i, req_vc_id_i, req_last_i, credit_v_i, credit_id_i,
    output grant_v_o, grant_oh_o, grant_id_o, grant_vc_id_o, credit_cnt_o, locked_o
  );
endinterface

// File: rtl/floo_sa_global.sv
// Output-port switch allocator: round-robin over eligible inputs, wormhole lock
// until the tail flit, and per-VC downstream credit counters.
module floo_sa_global #(
  parameter int NumInputs  = 5,
  parameter int NumVC      = 4,
  parameter int VCDepth    = 3,
  parameter int NumVCWidth = NumVC > 1 ? $clog2(NumVC) : 1,
  parameter int NumInWidth = NumInputs > 1 ? $clog2(NumInputs) : 1,
  parameter int CntWidth   = $clog2(VCDepth + 1)
) (
  input logic             clk_i,
  input logic             rst_i,
  floo_sa_global_if.slave bus
);

  typedef logic [NumInWidth-1:0] in_id_t;
  typedef logic [NumVCWidth-1:0] vc_id_t;
  typedef logic [CntWidth-1:0]   cnt_t;
  typedef enum logic {StUnlocked, StLocked} state_e;

  localparam cnt_t   CntMax = cnt_t'(VCDepth);
  localparam in_id_t LastIn = in_id_t'(NumInputs - 1);

  state_e               state_q, state_d;
  in_id_t               ptr_q, ptr_d;
  in_id_t               lock_id_q, lock_id_d;
  vc_id_t               lock_vc_q, lock_vc_d;
  cnt_t [NumVC-1:0]     cnt_q, cnt_d;

  logic [NumInputs-1:0] eligible;
  logic                 gnt_v;
  in_id_t               gnt_id;
  vc_id_t               gnt_vc;
  logic                 gnt_last;

  // With a single VC every id collapses to 0, so no out-of-range counter index.
  function automatic vc_id_t vc_of(input vc_id_t id);
    return (NumVC > 1) ? id : '0;
  endfunction

  always_comb begin
    for (int i = 0; i < NumInputs; i++) begin
      eligible[i] = bus.req_v_i[i] && (cnt_q[vc_of(bus.req_vc_id_i[i])] != '0);
    end
  end

  always_comb begin : arbiter
    int     idx;
    in_id_t cand;
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned and no latch is inferred.
    gnt_v = 1'b0;
    gnt_id = '0;
    idx = 0;
    cand = '0;
    if (state_q == StLocked) begin
      if (eligible[lock_id_q] && vc_of(bus.req_vc_id_i[lock_id_q]) == lock_vc_q) begin
        gnt_v = 1'b1;
        gnt_id = lock_id_q;
      end
    end else begin
      // Scan from the farthest offset down so the candidate nearest ptr wins last.
      for (int k = NumInputs - 1; k >= 0; k--) begin
        idx = int'(ptr_q) + k;
        if (idx >= NumInputs) idx -= NumInputs;
        cand = in_id_t'(idx);
        if (eligible[cand]) begin
          gnt_v = 1'b1;
          gnt_id = cand;
        end
      end
    end
    if (rst_i) begin
      gnt_v = 1'b0;
      gnt_id = '0;
    end
    gnt_vc = vc_of(bus.req_vc_id_i[gnt_id]);
    gnt_last = bus.req_last_i[gnt_id];
  end

  // State register.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q <= StUnlocked;
      ptr_q <= '0;
      lock_id_q <= '0;
      lock_vc_q <= '0;
      // NOTE: the credit array is a handful of flops, not a RAM, so it is
      // reset in full to the downstream buffer depth.
      cnt_q <= {NumVC{CntMax}};
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      lock_id_q <= lock_id_d;
      lock_vc_q <= lock_vc_d;
      cnt_q <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    lock_id_d = lock_id_q;
    lock_vc_d = lock_vc_q;
    if (gnt_v) begin
      if (gnt_last) begin
        state_d = StUnlocked;
        ptr_d = (gnt_id == LastIn) ? '0 : gnt_id + 1'b1;
      end else begin
        state_d = StLocked;
        lock_id_d = gnt_id;
        lock_vc_d = gnt_vc;
      end
    end
    for (int v = 0; v < NumVC; v++) begin
      logic inc, dec;
      inc = bus.credit_v_i && (vc_of(bus.credit_id_i) == vc_id_t'(v));
      dec = gnt_v && (gnt_vc == vc_id_t'(v));
      cnt_d[v] = cnt_q[v];
      if (inc && !dec && cnt_q[v] != CntMax) cnt_d[v] = cnt_q[v] + 1'b1;
      else if (dec && !inc)                  cnt_d[v] = cnt_q[v] - 1'b1;
    end
  end

  // Outputs.
  always_comb begin
    bus.grant_v_o = gnt_v;
    bus.grant_oh_o = gnt_v ? (NumInputs'(1) << gnt_id) : '0;
    bus.grant_id_o = gnt_id;
    bus.grant_vc_id_o = gnt_v ? gnt_vc : '0;
    bus.credit_cnt_o = cnt_q;
    bus.locked_o = (state_q == StLocked);
  end

  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert ($onehot0(bus.grant_oh_o)) else $error("grant_oh_o is not one-hot");
      assert (bus.grant_v_o == |bus.grant_oh_o) else $error("grant_v_o disagrees with grant_oh_o");
      assert (!gnt_v || cnt_q[gnt_vc] != '0) else $error("grant on VC %0d with no credit", gnt_vc);
      assert (!(bus.credit_v_i && cnt_q[vc_of(bus.credit_id_i)] == CntMax &&
                !(gnt_v && gnt_vc == vc_of(bus.credit_id_i))))
        else $warning("credit overflow on VC %0d, counter saturated", bus.credit_id_i);
    end
  end

endmodule

// File: tb/tb_floo_sa_global.sv
// Directed bench for floo_sa_global: expected grants go through a scoreboard
// queue; credit counters and lock state are checked against hand-derived values.
module tb_floo_sa_global;
  localparam int NumInputs  = 5;
  localparam int NumVC      = 4;
  localparam int VCDepth    = 3;
  localparam int NumVCWidth = 2;
  localparam int NumInWidth = 3;
  localparam int CntWidth   = 2;

  typedef struct {
    logic       v;
    logic [4:0] oh;
    logic [2:0] id;
    logic [1:0] vc;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  floo_sa_global_if #(
    .NumInputs(NumInputs), .NumVC(NumVC), .VCDepth(VCDepth),
    .NumVCWidth(NumVCWidth), .NumInWidth(NumInWidth), .CntWidth(CntWidth)
  ) bus ();

  floo_sa_global #(
    .NumInputs(NumInputs), .NumVC(NumVC), .VCDepth(VCDepth),
    .NumVCWidth(NumVCWidth), .NumInWidth(NumInWidth), .CntWidth(CntWidth)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0][1:0] vcs(input int v0, input int v1, input int v2,
                                          input int v3, input int v4);
    return {2'(v4), 2'(v3), 2'(v2), 2'(v1), 2'(v0)};
  endfunction

  task automatic drive(input logic [4:0] v, input logic [4:0][1:0] vc, input logic [4:0] last,
                       input logic cv = 1'b0, input logic [1:0] cid = 2'd0);
    bus.req_v_i = v;
    bus.req_vc_id_i = vc;
    bus.req_last_i = last;
    bus.credit_v_i = cv;
    bus.credit_id_i = cid;
  endtask

  // Push the expected grant, compare it mid-cycle, then step past the next edge.
  task automatic expect_grant(input string tag, input logic v, input int id, input int vc);
    exp_t e;
    e.v = v;
    e.id = v ? 3'(id) : 3'd0;
    e.vc = v ? 2'(vc) : 2'd0;
    e.oh = v ? 5'(1 << id) : 5'd0;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check({tag, ".v"},  32'(bus.grant_v_o),     32'(e.v));
    check({tag, ".oh"}, 32'(bus.grant_oh_o),    32'(e.oh));
    check({tag, ".id"}, 32'(bus.grant_id_o),    32'(e.id));
    check({tag, ".vc"}, 32'(bus.grant_vc_id_o), 32'(e.vc));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ovf_exp[4];
    ovf_exp = '{1, 2, 3, 3};

    // Reset with every input requesting: grants must be forced off.
    rst = 1'b1;
    drive(5'b11111, vcs(0, 0, 0, 0, 0), 5'b11111);
    expect_grant("in_reset", 1'b0, 0, 0);
    rst = 1'b0;
    for (int v = 0; v < NumVC; v++) check($sformatf("rst_cnt%0d", v), bus.credit_cnt_o[v], VCDepth);
    check("rst_locked", bus.locked_o, 0);

    // Round robin on VC0 until its credit runs out.
    drive(5'b10110, vcs(0, 0, 0, 0, 0), 5'b11111);
    expect_grant("rr_a", 1'b1, 1, 0);
    check("rr_a_cnt0", bus.credit_cnt_o[0], 2);
    expect_grant("rr_b", 1'b1, 2, 0);
    check("rr_b_cnt0", bus.credit_cnt_o[0], 1);
    expect_grant("rr_c", 1'b1, 4, 0);
    check("rr_c_cnt0", bus.credit_cnt_o[0], 0);
    expect_grant("no_credit", 1'b0, 0, 0);
    check("no_credit_cnt0", bus.credit_cnt_o[0], 0);

    // Move ptr to 3 with a single-flit grant from input 2 on VC3.
    drive(5'b00100, vcs(0, 0, 3, 0, 0), 5'b11111);
    expect_grant("setup_ptr", 1'b1, 2, 3);
    check("setup_cnt3", bus.credit_cnt_o[3], 2);

    // Three-flit packet from input 3 on VC1 while input 0 keeps requesting VC2.
    drive(5'b01001, vcs(2, 0, 0, 1, 0), 5'b10111);
    expect_grant("pkt_head", 1'b1, 3, 1);
    check("pkt_head_locked", bus.locked_o, 1);
    expect_grant("pkt_body", 1'b1, 3, 1);
    check("pkt_body_locked", bus.locked_o, 1);
    drive(5'b01001, vcs(2, 0, 0, 1, 0), 5'b11111);
    expect_grant("pkt_tail", 1'b1, 3, 1);
    check("pkt_tail_locked", bus.locked_o, 0);
    check("pkt_tail_cnt1", bus.credit_cnt_o[1], 0);
    drive(5'b00001, vcs(2, 0, 0, 0, 0), 5'b11111);
    expect_grant("after_tail", 1'b1, 0, 2);
    check("after_tail_cnt2", bus.credit_cnt_o[2], 2);

    // Grant and credit return on VC2 in the same cycle cancel out.
    expect_grant("vc2_a", 1'b1, 0, 2);
    check("vc2_a_cnt2", bus.credit_cnt_o[2], 1);
    drive(5'b00001, vcs(2, 0, 0, 0, 0), 5'b11111, 1'b1, 2'd2);
    expect_grant("vc2_net0", 1'b1, 0, 2);
    check("vc2_net0_cnt2", bus.credit_cnt_o[2], 1);
    drive(5'b00001, vcs(2, 0, 0, 0, 0), 5'b11111);
    expect_grant("vc2_again", 1'b1, 0, 2);
    check("vc2_again_cnt2", bus.credit_cnt_o[2], 0);

    // A returned credit is not usable in the cycle it arrives.
    drive(5'b00100, vcs(0, 0, 0, 0, 0), 5'b11111, 1'b1, 2'd0);
    expect_grant("no_bypass", 1'b0, 0, 0);
    check("no_bypass_cnt0", bus.credit_cnt_o[0], 1);

    // Lock to input 2 on VC0, consuming the last VC0 credit.
    drive(5'b00100, vcs(0, 0, 0, 0, 0), 5'b11011);
    expect_grant("lock2", 1'b1, 2, 0);
    check("lock2_locked", bus.locked_o, 1);
    check("lock2_cnt0", bus.credit_cnt_o[0], 0);
    drive(5'b00110, vcs(0, 3, 3, 0, 0), 5'b11111);
    expect_grant("lock_vc_mismatch", 1'b0, 0, 0);
    check("lock_vc_mismatch_locked", bus.locked_o, 1);
    drive(5'b00110, vcs(0, 3, 0, 0, 0), 5'b11111);
    expect_grant("lock_no_credit", 1'b0, 0, 0);
    check("lock_no_credit_locked", bus.locked_o, 1);
    drive(5'b00110, vcs(0, 3, 0, 0, 0), 5'b11111, 1'b1, 2'd0);
    expect_grant("lock_credit_ret", 1'b0, 0, 0);
    check("lock_credit_ret_cnt0", bus.credit_cnt_o[0], 1);
    drive(5'b00110, vcs(0, 3, 0, 0, 0), 5'b11111);
    expect_grant("lock_release", 1'b1, 2, 0);
    check("lock_release_locked", bus.locked_o, 0);
    drive(5'b00010, vcs(0, 3, 0, 0, 0), 5'b11111);
    expect_grant("after_lock", 1'b1, 1, 3);
    check("after_lock_cnt3", bus.credit_cnt_o[3], 1);

    // Fill VC1 to depth, then one extra return must saturate.
    for (int i = 0; i < 4; i++) begin
      drive(5'b00000, vcs(0, 0, 0, 0, 0), 5'b11111, 1'b1, 2'd1);
      expect_grant($sformatf("ovf%0d", i), 1'b0, 0, 0);
      check($sformatf("ovf%0d_cnt1", i), bus.credit_cnt_o[1], ovf_exp[i]);
    end

    // Two VC0 credits, then lock input 3 on VC0 leaving cnt[0]=1.
    drive(5'b00000, vcs(0, 0, 0, 0, 0), 5'b11111, 1'b1, 2'd0);
    expect_grant("ret0_a", 1'b0, 0, 0);
    expect_grant("ret0_b", 1'b0, 0, 0);
    drive(5'b01000, vcs(0, 0, 0, 0, 0), 5'b10111);
    expect_grant("lock3", 1'b1, 3, 0);
    check("lock3_locked", bus.locked_o, 1);
    check("lock3_cnt0", bus.credit_cnt_o[0], 1);

    // Reset mid-packet with the locked input's tail pending.
    rst = 1'b1;
    drive(5'b01000, vcs(0, 0, 0, 0, 0), 5'b11111);
    expect_grant("mid_reset", 1'b0, 0, 0);
    rst = 1'b0;
    drive(5'b00000, vcs(0, 0, 0, 0, 0), 5'b11111);
    check("post_rst_locked", bus.locked_o, 0);
    for (int v = 0; v < NumVC; v++) check($sformatf("post_rst_cnt%0d", v), bus.credit_cnt_o[v], VCDepth);
    expect_grant("post_rst_idle", 1'b0, 0, 0);
    drive(5'b10000, vcs(0, 0, 0, 0, 1), 5'b11111);
    expect_grant("wrap_to4", 1'b1, 4, 1);
    drive(5'b10001, vcs(2, 0, 0, 0, 1), 5'b11111);
    expect_grant("wrap_to0", 1'b1, 0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
